// File: rtl/cascaded_mod_counter.sv
// cascaded_mod_counter: two-stage modulo counter with enable, direction, clear, clamped load, wrap and overflow flags
module cascaded_mod_counter #(
  parameter int W1 = 4,
  parameter int W2 = 3,
  parameter int MOD1 = 10,
  parameter int MOD2 = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [W1-1:0] ld_q1,
  input  logic [W2-1:0] ld_q2,
  output logic [W1-1:0] Q1,
  output logic [W2-1:0] Q2,
  output logic          tc1,
  output logic          tc,
  output logic          wrap,
  output logic          ovf
);
  if (MOD1 < 2 || MOD1 > (1 << W1)) begin : g_bad_mod1
    $fatal(1, "cascaded_mod_counter: MOD1 out of range 2..2**W1");
  end
  if (MOD2 < 2 || MOD2 > (1 << W2)) begin : g_bad_mod2
    $fatal(1, "cascaded_mod_counter: MOD2 out of range 2..2**W2");
  end
  localparam logic [W1-1:0] max1 = W1'(MOD1 - 1);
  localparam logic [W2-1:0] max2 = W2'(MOD2 - 1);
  localparam logic [W1-1:0] one1 = W1'(1);
  localparam logic [W2-1:0] one2 = W2'(1);
  logic          end1, end2;
  logic [W1-1:0] q1_n;
  logic [W2-1:0] q2_n;
  // stage boundaries, carry flags and next count (clr > load > en); stage 2 moves only on a stage-1 carry/borrow
  always_comb begin
    end1 = up ? Q1 == max1 : Q1 == '0;
    end2 = up ? Q2 == max2 : Q2 == '0;
    tc1  = en & end1;
    tc   = tc1 & end2;
    q1_n = clr ? '0 : load ? (ld_q1 > max1 ? max1 : ld_q1) : !en ? Q1 :
           end1 ? (up ? '0 : max1) : up ? Q1 + one1 : Q1 - one1;
    q2_n = clr ? '0 : load ? (ld_q2 > max2 ? max2 : ld_q2) : !tc1 ? Q2 :
           end2 ? (up ? '0 : max2) : up ? Q2 + one2 : Q2 - one2;
  end
  // count and flag registers; wrap pulses after a full-chain wrap, ovf is sticky until clr or reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      Q1   <= '0;
      Q2   <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      Q1   <= q1_n;
      Q2   <= q2_n;
      wrap <= tc & ~clr & ~load;
      ovf  <= ~clr & (ovf | (tc & ~load));
    end
endmodule

// File: doc/cascaded_mod_counter.md
Name: cascaded_mod_counter

Overview:
Two-stage cascaded modulo counter with parametrised stage widths and moduli. It generalises the fixed 4-bit/3-bit Q1/Q2 counter pair into a configurable timebase, for example mod-10 by mod-6 for a seconds digit pair. Added features over the fixed pair: enable, up/down direction, synchronous clear, parallel load with clamping, terminal-count and wrap flags, and a sticky overflow. Used as the digit/timebase counter feeding display and timer blocks.

Parameters:
W1, 4, width of stage-1 count Q1
W2, 3, width of stage-2 count Q2
MOD1, 10, stage-1 modulus; legal range 2..2**W1
MOD2, 6, stage-2 modulus; legal range 2..2**W2

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous, active-low reset; rst=0 resets immediately
en  in  1  count enable
up  in  1  direction: 1 = up, 0 = down
clr  in  1  synchronous clear, highest synchronous priority
load  in  1  synchronous parallel load
ld_q1  in  W1  load value for Q1
ld_q2  in  W2  load value for Q2
Q1  out  W1  stage-1 count (registered)
Q2  out  W2  stage-2 count (registered)
tc1  out  1  combinational; stage-1 carry/borrow into stage 2
tc  out  1  combinational; full-chain terminal count
wrap  out  1  registered one-cycle pulse after a full-chain wrap
ovf  out  1  registered sticky flag, set on any full-chain wrap

Behaviour:
- Reset (rst=0, asynchronous): Q1=0, Q2=0, wrap=0, ovf=0. The reset value holds while rst=0. Counting resumes on the first rising edge after rst returns to 1.
- Synchronous priority per edge: clr > load > en. When none is active, all registers hold.
- clr=1: Q1=0, Q2=0, wrap=0, ovf=0. load and en are ignored on that edge.
- load=1 (clr=0): Q1 = min(ld_q1, MOD1-1) and Q2 = min(ld_q2, MOD2-1), so out-of-range values clamp to the maximum. wrap is forced to 0; ovf holds.
- en=1, up=1:
  - Q1 != MOD1-1: Q1 = Q1+1.
  - Q1 == MOD1-1: Q1 = 0 and Q2 advances.
  - Q2 advances to Q2+1, or wraps to 0 when it is at MOD2-1.
  - Both stages at maximum: the next edge gives Q1=0, Q2=0. This is a full wrap.
- en=1, up=0:
  - Q1 != 0: Q1 = Q1-1.
  - Q1 == 0: Q1 = MOD1-1 and Q2 decrements, or wraps from 0 to MOD2-1.
  - Both stages at 0: the next edge gives Q1=MOD1-1, Q2=MOD2-1. This is a full wrap.
- tc1 = en & (up ? Q1==MOD1-1 : Q1==0). No clr/load gating is applied to tc1.
- tc = tc1 & (up ? Q2==MOD2-1 : Q2==0).
- wrap: registered copy of (tc & ~clr & ~load). It is high for exactly the one cycle after the wrapping edge.
- ovf: set on the same edge that wrap is set. Only clr or rst clears it; load does not.
- Direction change: up may change on any cycle. The new direction applies at the next edge, with no extra latency and no skipped value.
- en=0: Q1, Q2 and ovf hold. wrap returns to 0 on the next edge. tc1 and tc are 0.
- Latency:
  - Q1/Q2 change one edge after inputs are sampled.
  - tc1/tc follow inputs combinationally.
  - wrap lags tc by one edge.
- Elaboration: an illegal MOD1/MOD2 (below 2 or exceeding 2**W) is a fatal elaboration error. MOD = 2**W is legal and is natural binary rollover.
- Q1 values at or above MOD1 are unreachable after reset, clr or load. The same holds for Q2 and MOD2.

Test Plan:
1. Reset, then en=1, up=1 for 60 edges (defaults) -> Q1 counts 0..9 repeatedly. Q2 steps on each Q1 9->0 and reaches 5. At Q1=9, Q2=5: tc=1. Next edge: Q1=0, Q2=0, then wrap=1 for one cycle, ovf=1.
2. Load ld_q1=0, ld_q2=0, then en=1, up=0 -> one edge gives Q1=9, Q2=5, wrap pulses once, ovf=1. Further edges give 8/5, 7/5, ...; after 0/5 comes 9/4.
3. load with ld_q1=15, ld_q2=7 -> Q1=9, Q2=5 (clamped); ovf unchanged.
4. At Q1=9, Q2=5 with up=1, en=1: assert clr and load together -> Q1=0, Q2=0, wrap=0, ovf=0. No wrap pulse follows.
5. Mid-count at Q1=7, Q2=3: drop en for 5 cycles -> values hold, tc1=0. Toggle up with en=1 -> 8/3, then 7/3.
6. Drive rst=0 mid-cycle at Q1=4, Q2=2 -> outputs are 0 immediately, without waiting for a clock edge. After release, the first enabled edge gives Q1=1.
   - Repeat with W1=5, MOD1=32, W2=2, MOD2=3 -> rollover 31->0 advances Q2, and the full wrap occurs at 31/2.
